// File: rtl/sprite_draw_sequencer.sv
// sprite_draw_sequencer: per-frame scheduler that walks a sprite table and
// issues one draw command per active entry to the downstream sprite drawer,
// waiting for each draw to finish before issuing the next.
// Optional feature macro: SPRITE_SEQ_PENDING_EN (one-deep queued restart
// when frame_start arrives while a pass is still running).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no pass in progress, waiting for frame_start
// SCAN      | examine table entry idx, issue command if active
// WAIT_LOW  | command issued, waiting for the drawer to drop done
// WAIT_HIGH | drawer busy, waiting for done to return high
// ADV       | step to next index or finish the pass
module sprite_draw_sequencer #(
  parameter int NUM_SPRITES = 16,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_idx,
  input  logic [16:0]       tbl_coord,
  input  logic [7:0]        tbl_img,
  input  logic              tbl_active,
  input  logic              frame_start,
  output logic              draw_start,
  output logic [16:0]       draw_coord,
  output logic [7:0]        draw_img,
  input  logic              draw_done,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [IDX_W:0]    drawn_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_SPRITES - 1);
  localparam logic [IDX_W:0]   NUM_ENTRIES = (IDX_W+1)'(NUM_SPRITES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    ADV       = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W:0]    run_cnt_q, run_cnt_d;
  logic [IDX_W:0]    drawn_cnt_q, drawn_cnt_d;
  logic              draw_start_q, draw_start_d;
  logic [16:0]       draw_coord_q, draw_coord_d;
  logic [7:0]        draw_img_q, draw_img_d;
  logic              overrun_q, overrun_d;
  logic              busy_w;
  logic              last_adv;
  logic              restart;

  logic [16:0]       tbl_coord_q  [NUM_SPRITES];
  logic [7:0]        tbl_img_q    [NUM_SPRITES];
  logic              tbl_active_q [NUM_SPRITES];

  // Table storage: game-logic writes, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tbl_coord_q[i]  <= '0;
        tbl_img_q[i]    <= '0;
        tbl_active_q[i] <= 1'b0;
      end
    end else if (tbl_we && ({1'b0, tbl_idx} < NUM_ENTRIES)) begin
      tbl_coord_q[tbl_idx]  <= tbl_coord;
      tbl_img_q[tbl_idx]    <= tbl_img;
      tbl_active_q[tbl_idx] <= tbl_active;
    end
  end

  assign busy_w   = (state_q != IDLE);
  assign last_adv = (state_q == ADV) && (idx_q == LAST_IDX);

`ifdef SPRITE_SEQ_PENDING_EN
  logic pending_q, pending_d;

  // A frame_start landing in the final ADV cycle is folded into the restart.
  assign restart = pending_q | frame_start;

  // Pending flag: one-deep, further overruns are absorbed.
  always_comb begin
    pending_d = pending_q;
    if (last_adv) begin
      pending_d = 1'b0;
    end else if (frame_start && busy_w) begin
      pending_d = 1'b1;
    end
  end

  // Pending flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  assign restart = 1'b0;
`endif

  // Next-state and registered-output logic for the draw walk.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    run_cnt_d    = run_cnt_q;
    drawn_cnt_d  = drawn_cnt_q;
    draw_start_d = 1'b0;
    draw_coord_d = draw_coord_q;
    draw_img_d   = draw_img_q;
    overrun_d    = frame_start && busy_w;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = SCAN;
          idx_d     = '0;
          run_cnt_d = '0;
        end
      end
      SCAN: begin
        if (tbl_active_q[idx_q]) begin
          draw_start_d = 1'b1;
          draw_coord_d = tbl_coord_q[idx_q];
          draw_img_d   = tbl_img_q[idx_q];
          state_d      = WAIT_LOW;
        end else begin
          state_d = ADV;
        end
      end
      WAIT_LOW: begin
        if (!draw_done) begin
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (draw_done) begin
          run_cnt_d = run_cnt_q + 1'b1;
          state_d   = ADV;
        end
      end
      ADV: begin
        if (idx_q == LAST_IDX) begin
          drawn_cnt_d = run_cnt_q;
          if (restart) begin
            state_d   = SCAN;
            idx_d     = '0;
            run_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any pass in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      run_cnt_q    <= '0;
      drawn_cnt_q  <= '0;
      draw_start_q <= 1'b0;
      draw_coord_q <= '0;
      draw_img_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_cnt_q    <= run_cnt_d;
      drawn_cnt_q  <= drawn_cnt_d;
      draw_start_q <= draw_start_d;
      draw_coord_q <= draw_coord_d;
      draw_img_q   <= draw_img_d;
      overrun_q    <= overrun_d;
    end
  end

  assign draw_start = draw_start_q;
  assign draw_coord = draw_coord_q;
  assign draw_img   = draw_img_q;
  assign busy       = busy_w;
  assign frame_done = last_adv;
  assign overrun    = overrun_q;
  assign drawn_cnt  = drawn_cnt_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench for sprite_draw_sequencer with a drawer model that holds
// done low for 10 cycles after each start pulse.
module tb_sprite_draw_sequencer;

  localparam int NS = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tbl_we;
  logic [IW-1:0] tbl_idx;
  logic [16:0]   tbl_coord;
  logic [7:0]    tbl_img;
  logic          tbl_active;
  logic          frame_start;
  logic          draw_start;
  logic [16:0]   draw_coord;
  logic [7:0]    draw_img;
  logic          draw_done;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic [IW:0]   drawn_cnt;

  int checks = 0;
  int errors = 0;

  sprite_draw_sequencer #(.NUM_SPRITES(NS), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_coord(tbl_coord), .tbl_img(tbl_img), .tbl_active(tbl_active),
    .frame_start(frame_start), .draw_start(draw_start),
    .draw_coord(draw_coord), .draw_img(draw_img), .draw_done(draw_done),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .drawn_cnt(drawn_cnt)
  );

  always #5 clk = ~clk;

  // drawer model: done drops the cycle after start and stays low 10 cycles
  logic [4:0] dcnt = '0;
  always @(posedge clk) begin
    if (draw_start) dcnt <= 5'd10;
    else if (dcnt != 0) dcnt <= dcnt - 5'd1;
  end
  assign draw_done = (dcnt == 5'd0);

  // monitor: log commands and pulses
  logic [16:0] mon_coord [$];
  logic [7:0]  mon_img   [$];
  int fd_cnt = 0, ov_cnt = 0, early_cnt = 0;
  always @(negedge clk) begin
    if (draw_start) begin
      mon_coord.push_back(draw_coord);
      mon_img.push_back(draw_img);
      if (!draw_done) early_cnt++;
    end
    if (frame_done) fd_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input int idx, input logic [16:0] c, input logic [7:0] im, input logic act);
    @(negedge clk);
    tbl_we = 1'b1; tbl_idx = IW'(idx); tbl_coord = c; tbl_img = im; tbl_active = act;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  // returns at the negedge of the first SCAN cycle
  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // called at the negedge of the first SCAN cycle; n counts cycles after the edge
  task automatic wait_frame_done(input int budget, output int n);
    n = 1;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  int n, q0, fd0, ov0;

  initial begin
    rst = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_coord = '0; tbl_img = '0;
    tbl_active = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_draw_start", {31'd0, draw_start}, 32'd0);
    chk("rst_draw_coord", {15'd0, draw_coord}, 32'd0);
    chk("rst_draw_img", {24'd0, draw_img}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_drawn_cnt", {27'd0, drawn_cnt}, 32'd0);

    // two active entries
    write_entry(0, 17'h00A05, 8'h03, 1'b1);
    write_entry(5, 17'h1F000, 8'h7F, 1'b1);
    q0 = mon_coord.size();
    pulse_fs();
    chk("pass_busy_t1", {31'd0, busy}, 32'd1);
    wait_frame_done(200, n);
    @(negedge clk);
    chk("two_cmd_count", 32'(mon_coord.size() - q0), 32'd2);
    if (mon_coord.size() >= q0 + 2) begin
      chk("cmd0_coord", {15'd0, mon_coord[q0]}, 32'h00A05);
      chk("cmd0_img", {24'd0, mon_img[q0]}, 32'h03);
      chk("cmd1_coord", {15'd0, mon_coord[q0+1]}, 32'h1F000);
      chk("cmd1_img", {24'd0, mon_img[q0+1]}, 32'h7F);
    end
    chk("two_drawn_cnt", {27'd0, drawn_cnt}, 32'd2);
    chk("two_busy_after", {31'd0, busy}, 32'd0);

    // all inactive: 2 cycles per entry
    write_entry(0, 17'h0, 8'h0, 1'b0);
    write_entry(5, 17'h0, 8'h0, 1'b0);
    q0 = mon_coord.size();
    pulse_fs();
    wait_frame_done(100, n);
    chk("empty_latency", 32'(n), 32'd32);
    @(negedge clk);
    chk("empty_no_cmd", 32'(mon_coord.size() - q0), 32'd0);
    chk("empty_drawn_cnt", {27'd0, drawn_cnt}, 32'd0);
    chk("hold_coord", {15'd0, draw_coord}, 32'h1F000);

    // all sixteen active
    for (int i = 0; i < NS; i++) write_entry(i, 17'(i * 3 + 1), 8'(i + 8'h40), 1'b1);
    q0 = mon_coord.size();
    fd0 = early_cnt;
    pulse_fs();
    wait_frame_done(600, n);
    @(negedge clk);
    chk("full_cmd_count", 32'(mon_coord.size() - q0), 32'd16);
    chk("full_no_early", 32'(early_cnt - fd0), 32'd0);
    chk("full_drawn_cnt", {27'd0, drawn_cnt}, 32'd16);
    if (mon_coord.size() >= q0 + 16)
      for (int i = 0; i < NS; i++) chk("full_coord", {15'd0, mon_coord[q0+i]}, 32'(i * 3 + 1));

    // overrun mid-pass
    fd0 = fd_cnt;
    ov0 = ov_cnt;
    pulse_fs();
    repeat (20) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_frame_done(600, n);
    @(negedge clk);
`ifdef SPRITE_SEQ_PENDING_EN
    chk("pend_busy_kept", {31'd0, busy}, 32'd1);
    wait_frame_done(600, n);
    @(negedge clk);
    chk("pend_busy_after", {31'd0, busy}, 32'd0);
    chk("pend_fd_pulses", 32'(fd_cnt - fd0), 32'd2);
`else
    chk("ovr_busy_after", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("ovr_fd_pulses", 32'(fd_cnt - fd0), 32'd1);
`endif
    chk("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);

    // same-cycle write to scanned index is not seen; later index is
    for (int i = 0; i < NS; i++) write_entry(i, 17'h0, 8'h0, 1'b0);
    q0 = mon_coord.size();
    pulse_fs();
    repeat (6) @(negedge clk);
    tbl_we = 1'b1; tbl_idx = 4'd3; tbl_coord = 17'h00333; tbl_img = 8'h33; tbl_active = 1'b1;
    @(negedge clk);
    tbl_idx = 4'd9; tbl_coord = 17'h12345; tbl_img = 8'h99; tbl_active = 1'b1;
    @(negedge clk);
    tbl_we = 1'b0;
    wait_frame_done(200, n);
    @(negedge clk);
    chk("mid_cmd_count", 32'(mon_coord.size() - q0), 32'd1);
    if (mon_coord.size() >= q0 + 1) begin
      chk("mid_coord", {15'd0, mon_coord[q0]}, 32'h12345);
      chk("mid_img", {24'd0, mon_img[q0]}, 32'h99);
    end
    chk("mid_drawn_cnt", {27'd0, drawn_cnt}, 32'd1);

    // reset during WAIT_HIGH
    write_entry(0, 17'h00001, 8'h01, 1'b1);
    pulse_fs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rwh_draw_start", {31'd0, draw_start}, 32'd0);
    chk("rwh_draw_coord", {15'd0, draw_coord}, 32'd0);
    chk("rwh_draw_img", {24'd0, draw_img}, 32'd0);
    chk("rwh_busy", {31'd0, busy}, 32'd0);
    chk("rwh_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rwh_drawn_cnt", {27'd0, drawn_cnt}, 32'd0);
    q0 = mon_coord.size();
    pulse_fs();
    wait_frame_done(100, n);
    chk("rwh_latency", 32'(n), 32'd32);
    @(negedge clk);
    chk("rwh_no_cmd", 32'(mon_coord.size() - q0), 32'd0);
    chk("rwh_pass_cnt", {27'd0, drawn_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_draw_sequencer.md
# sprite_draw_sequencer

Per-frame scheduler that sits directly upstream of the sprite drawer and drives its `start` / `coordinates` / `img_sel` / `done` handshake. It holds a table of sprite entries written by game logic. On each frame-start pulse it walks the table in index order and issues one draw command per active entry. It waits for the drawer to finish each sprite before issuing the next, then reports pass completion.

## Interface
Parameters:
- `NUM_SPRITES`, 16: number of table entries; 1..2^`IDX_W`.
- `IDX_W`, 4: table index width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tbl_we`  in  1  table write strobe.
- `tbl_idx`  in  IDX_W  entry to write.
- `tbl_coord`  in  17  sprite frame coordinates.
- `tbl_img`  in  8  sprite image select.
- `tbl_active`  in  1  entry enabled for drawing.
- `frame_start`  in  1  one-cycle pulse that begins a draw pass.
- `draw_start`  out  1  one-cycle start pulse to the drawer (registered).
- `draw_coord`  out  17  coordinates for the drawer (registered; held between commands).
- `draw_img`  out  8  image select for the drawer (registered; held).
- `draw_done`  in  1  drawer done level: high when idle, low while drawing.
- `busy`  out  1  high while a pass is in progress.
- `frame_done`  out  1  one-cycle pulse when a pass completes.
- `overrun`  out  1  one-cycle pulse when `frame_start` arrives while `busy`.
- `drawn_cnt`  out  IDX_W+1  count of sprites drawn in the last completed pass.

## Operation
- **Table**
  - `NUM_SPRITES` registered entries of {coord[16:0], img[7:0], active}.
  - Write occurs at `clk` when `tbl_we` is high.
  - Writes with `tbl_idx >= NUM_SPRITES` are ignored.
  - Writes are allowed at any time, including mid-pass.
- **States**
  - IDLE: `busy`=0.
    - `frame_start` -> SCAN, with idx=0 and the running count=0.
  - SCAN: examine entry[idx].
    - Active: register `draw_start`=1, `draw_coord`, `draw_img`; go to WAIT_LOW.
    - Inactive: go to ADV.
  - WAIT_LOW: `draw_start` is high for exactly this one cycle.
    - Stay until `draw_done`==0, then go to WAIT_HIGH.
  - WAIT_HIGH: stay until `draw_done`==1.
    - Then increment the running count and go to ADV.
  - ADV:
    - If idx==`NUM_SPRITES`-1: copy the running count to `drawn_cnt`, pulse `frame_done`, go to IDLE.
    - Otherwise: idx+1, go to SCAN.
- **Table reads**
  - Entry values are read from the table registers in SCAN.
  - A write to the same index in that same cycle is not seen by the current command.
  - A write to a later index mid-pass is seen when that index is scanned.
- **Overrun**
  - `frame_start` while `busy`=1 pulses `overrun` the next cycle.
  - Handling of that `frame_start` is set by the Configuration section.
- **Counter width**
  - The running count is IDX_W+1 bits and never wraps, because it is at most `NUM_SPRITES`.

## Timing
- **Reset**
  - `rst` high at any edge forces IDLE and clears all table entries to 0, including the active bits.
  - All outputs reset to 0: `draw_start`, `draw_coord`, `draw_img`, `busy`, `frame_done`, `overrun`, `drawn_cnt`.
  - Reset mid-pass drops the pass with no `frame_done`.
  - Reset mid-pass does not wait for the drawer.
- **Pass start**
  - `frame_start` sampled high at edge T (in IDLE).
  - SCAN idx 0 in cycle T+1.
  - `busy` is high from T+1 until the cycle after `frame_done`.
- **Command latency**
  - Active entry in SCAN at cycle C gives `draw_start`=1 in cycle C+1.
  - The drawer drops done in C+2, so WAIT_LOW exits after one cycle against the standard drawer.
- **Skipping**
  - Each inactive entry costs 2 cycles (SCAN, ADV).
  - A pass over an all-inactive table takes 2·`NUM_SPRITES` cycles after the `frame_start` edge.
  - `frame_done` is asserted in the final ADV cycle.
- **Simultaneous events**
  - `frame_done` and a new `frame_start` in the same cycle: the `frame_start` counts as overrun, because `busy` is still 1.
- **Output holding**
  - `draw_coord` and `draw_img` hold their last values between commands.

## Configuration
- **`SPRITE_SEQ_PENDING_EN` defined**
  - A `frame_start` during `busy` sets a one-deep pending flag; further ones are absorbed.
  - At the end of a pass with pending set, the block goes from ADV directly to SCAN idx 0, clears pending, and still pulses `frame_done`. `busy` stays high.
  - Reset clears pending.
- **Not defined**
  - An overrun `frame_start` is dropped; only `overrun` pulses.
- **Both**
  - `overrun` behaviour is identical.

## Test plan
- Reset, then write entries 0 (coord 17'h00A05, img 8'h03) and 5 (coord 17'h1F000, img 8'h7F) active, pulse `frame_start`, with a drawer model that holds done low 10 cycles.
  - Required: exactly two `draw_start` pulses with those values in index order, then `frame_done` and `drawn_cnt`=2.
- All entries inactive, `frame_start`.
  - Required: no `draw_start`, `frame_done` 32 cycles after the `frame_start` edge (`NUM_SPRITES`=16), `drawn_cnt`=0.
- All 16 active.
  - Required: 16 commands, each issued only after `draw_done` returns high; `drawn_cnt`=16 (5'b10000).
- `frame_start` mid-pass.
  - Required: `overrun` pulses once.
  - Without `SPRITE_SEQ_PENDING_EN`: `busy` falls after `frame_done`.
  - With `SPRITE_SEQ_PENDING_EN`: a second pass starts immediately, 2 `frame_done` pulses total.
- Write entry 3 inactive -> active in the same cycle SCAN reads idx 3, and write entry 9 active mid-pass.
  - Required: entry 3 is skipped this pass; entry 9 is drawn.
- Assert `rst` during WAIT_HIGH.
  - Required: next cycle all outputs are 0 and the state is IDLE; a later `frame_start` with the cleared table yields `drawn_cnt`=0.
